uart_tx_fifo: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8-bit serializer. Adds a configurable data width, an internal baud divider, optional parity, 1 or 2 stop bits, selectable bit order and a small input FIFO, so the host can queue several words without polling tx_busy. Sits between the host/bus side and the TXD pad.

---
 rtl/uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, baud divider, optional parity and 1/2 stop bits.
// Frames are sent back-to-back while the FIFO holds words; TXD is registered and idles high.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 send,
    output logic                 TXD,
    output logic                 tx_busy,
    output logic                 tx_full,
    output logic                 tx_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_msb_first
        $error("uart_tx_fifo: MSB_FIRST must be 0 or 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- input FIFO ----------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Full comes from the pre-edge count, so a same-edge pop never frees a slot for the push.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_push  = send && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; r_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // ---------------- serializer ----------------
    state_t               r_state;
    state_t               w_state_next;
    logic [BAUD_W-1:0]    r_baud;
    logic [BAUD_W-1:0]    w_baud_next;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] w_shifted;
    logic                 r_par;
    logic                 w_par_next;
    logic                 w_head_par;
    logic                 r_txd;
    logic                 w_txd_next;
    logic                 w_sr_out;
    logic                 w_baud_done;
    logic                 r_busy;
    logic                 r_overflow;

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_sr_out    = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];
    assign w_shifted   = (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], 1'b0}
                                          : {1'b0, r_shift[DATA_BITS-1:1]};
    assign w_head_par  = (PARITY == 1) ? ~(^w_head) : (^w_head);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_next  = 1'b1;
                w_baud_next = '0;
                w_bit_next  = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_par_next   = w_head_par;
                    w_txd_next   = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (!w_baud_done) begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end else begin
                    w_baud_next = '0;
                    case (r_state)
                        S_START: begin
                            w_state_next = S_DATA;
                            w_txd_next   = w_sr_out;
                            w_shift_next = w_shifted;
                            w_bit_next   = '0;
                        end
                        S_DATA: begin
                            if (r_bit_cnt == DATA_LAST) begin
                                w_bit_next = '0;
                                if (PARITY != 0) begin
                                    w_state_next = S_PARITY;
                                    w_txd_next   = r_par;
                                end else begin
                                    w_state_next = S_STOP;
                                    w_txd_next   = 1'b1;
                                end
                            end else begin
                                w_bit_next   = r_bit_cnt + BIT_W'(1);
                                w_txd_next   = w_sr_out;
                                w_shift_next = w_shifted;
                            end
                        end
                        S_PARITY: begin
                            w_state_next = S_STOP;
                            w_txd_next   = 1'b1;
                            w_bit_next   = '0;
                        end
                        default: begin
                            if (r_bit_cnt != STOP_LAST) begin
                                w_bit_next = r_bit_cnt + BIT_W'(1);
                            end else if (!w_empty) begin
                                // Next word starts on this edge: no idle gap between frames.
                                w_pop        = 1'b1;
                                w_shift_next = w_head;
                                w_par_next   = w_head_par;
                                w_txd_next   = 1'b0;
                                w_bit_next   = '0;
                                w_state_next = S_START;
                            end else begin
                                w_txd_next   = 1'b1;
                                w_bit_next   = '0;
                                w_state_next = S_IDLE;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_txd_next   = 1'b1;
                w_baud_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_baud     <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_txd      <= w_txd_next;
            r_busy     <= (w_state_next != S_IDLE) || (w_count_next != '0);
            r_overflow <= send && w_full;
        end
    end

    assign TXD         = r_txd;
    assign tx_busy     = r_busy;
    assign tx_full     = w_full;
    assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover even/odd parity, MSB-first,
// 7-bit/2-stop framing, FIFO overflow, back-to-back frames, async reset and data hold.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_v [4];
    logic [7:0] data_v [4];
    logic       txd_v  [4];
    logic       busy_v [4];
    logic       full_v [4];
    logic       ovf_v  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0: 8 bits, even parity, 1 stop, LSB first
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1),
                   .MSB_FIRST(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .tx_data(data_v[0]), .send(send_v[0]),
        .TXD(txd_v[0]), .tx_busy(busy_v[0]), .tx_full(full_v[0]), .tx_overflow(ovf_v[0]));

    // u1: odd parity
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1),
                   .MSB_FIRST(0), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .tx_data(data_v[1]), .send(send_v[1]),
        .TXD(txd_v[1]), .tx_busy(busy_v[1]), .tx_full(full_v[1]), .tx_overflow(ovf_v[1]));

    // u2: MSB first, no parity
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1),
                   .MSB_FIRST(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .tx_data(data_v[2]), .send(send_v[2]),
        .TXD(txd_v[2]), .tx_busy(busy_v[2]), .tx_full(full_v[2]), .tx_overflow(ovf_v[2]));

    // u3: 7 bits, no parity, 2 stop bits
    uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2),
                   .MSB_FIRST(0), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .reset(reset), .tx_data(data_v[3][6:0]), .send(send_v[3]),
        .TXD(txd_v[3]), .tx_busy(busy_v[3]), .tx_full(full_v[3]), .tx_overflow(ovf_v[3]));

    // Frame for u0 as a bit list, index 0 = first bit on the line.
    function automatic logic [10:0] frame8e(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    // Called at a negedge; holds send for one edge and returns at the following negedge.
    task automatic push(input int idx, input logic [7:0] d);
        send_v[idx] = 1'b1;
        data_v[idx] = d;
        @(negedge clk);
        send_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_v[i] = 1'b0;
            data_v[i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        checks++; if (txd_v[0] !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
        checks++; if (full_v[0] !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full_v[0]); end
        checks++; if (ovf_v[0] !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_v[0]); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_a5();
        logic [10:0] exp;
        exp = 11'b10101001010;
        push(0, 8'hA5);
        checks++; if (txd_v[0] !== 1'b1) begin errors++; $display("FAIL a5_latency_txd: got %b want 1", txd_v[0]); end
        checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL a5_busy_after_push: got %b want 1", busy_v[0]); end
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checks++;
                if (txd_v[0] !== exp[b]) begin
                    errors++; $display("FAIL a5_frame bit %0d cyc %0d: got %b want %b", b, c, txd_v[0], exp[b]);
                end
                checks++;
                if (busy_v[0] !== 1'b1) begin
                    errors++; $display("FAIL a5_busy bit %0d cyc %0d: got %b want 1", b, c, busy_v[0]);
                end
                @(negedge clk);
            end
        end
        checks++; if (txd_v[0] !== 1'b1) begin errors++; $display("FAIL a5_idle_txd: got %b want 1", txd_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL a5_idle_busy: got %b want 0", busy_v[0]); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_odd_parity();
        logic [10:0] exp;
        exp = 11'b11000000000;
        push(1, 8'h00);
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checks++;
                if (txd_v[1] !== exp[b]) begin
                    errors++; $display("FAIL odd_frame bit %0d cyc %0d: got %b want %b", b, c, txd_v[1], exp[b]);
                end
                @(negedge clk);
            end
        end
        checks++; if (busy_v[1] !== 1'b0) begin errors++; $display("FAIL odd_idle_busy: got %b want 0", busy_v[1]); end
    endtask

    task automatic test_msb_first();
        logic [9:0] exp;
        exp = 10'b1000000010;
        push(2, 8'h80);
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checks++;
                if (txd_v[2] !== exp[b]) begin
                    errors++; $display("FAIL msb_frame bit %0d cyc %0d: got %b want %b", b, c, txd_v[2], exp[b]);
                end
                @(negedge clk);
            end
        end
        checks++; if (busy_v[2] !== 1'b0) begin errors++; $display("FAIL msb_idle_busy: got %b want 0", busy_v[2]); end
    endtask

    task automatic test_two_stop();
        logic [19:0] exp;
        // 0x55 then 0x00, 7 data bits, 2 stop bits, second start directly after the stops
        exp = {10'b1100000000, 10'b1110101010};
        send_v[3] = 1'b1;
        data_v[3] = 8'h55;
        @(negedge clk);
        data_v[3] = 8'h00;
        @(negedge clk);
        send_v[3] = 1'b0;
        for (int b = 0; b < 20; b++) begin
            for (int c = 0; c < CPB; c++) begin
                checks++;
                if (txd_v[3] !== exp[b]) begin
                    errors++; $display("FAIL stop2_frames bit %0d cyc %0d: got %b want %b", b, c, txd_v[3], exp[b]);
                end
                @(negedge clk);
            end
        end
        checks++; if (txd_v[3] !== 1'b1) begin errors++; $display("FAIL stop2_idle_txd: got %b want 1", txd_v[3]); end
        checks++; if (busy_v[3] !== 1'b0) begin errors++; $display("FAIL stop2_idle_busy: got %b want 0", busy_v[3]); end
    endtask

    task automatic test_overflow_back_to_back();
        logic        samp [$];
        logic [10:0] exp;
        logic        low_seen;
        send_v[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            data_v[0] = 8'(k);
            @(negedge clk);
            if (k >= 2) samp.push_back(txd_v[0]);
            if (k == 5) begin
                checks++; if (full_v[0] !== 1'b1) begin errors++; $display("FAIL ovf_full_e5: got %b want 1", full_v[0]); end
                checks++; if (ovf_v[0] !== 1'b0) begin errors++; $display("FAIL ovf_pulse_e5: got %b want 0", ovf_v[0]); end
            end
            if (k == 6) begin
                checks++; if (ovf_v[0] !== 1'b1) begin errors++; $display("FAIL ovf_pulse_e6: got %b want 1", ovf_v[0]); end
                checks++; if (full_v[0] !== 1'b1) begin errors++; $display("FAIL ovf_full_e6: got %b want 1", full_v[0]); end
            end
        end
        send_v[0] = 1'b0;
        for (int j = 0; samp.size() < 5 * 44; j++) begin
            @(negedge clk);
            if (j == 0) begin
                checks++; if (ovf_v[0] !== 1'b0) begin errors++; $display("FAIL ovf_pulse_e7: got %b want 0", ovf_v[0]); end
            end
            samp.push_back(txd_v[0]);
        end
        for (int j = 0; j < 5 * 44; j++) begin
            exp = frame8e(8'(j / 44 + 1));
            checks++;
            if (samp[j] !== exp[(j % 44) / CPB]) begin
                errors++; $display("FAIL b2b_stream cyc %0d: got %b want %b", j, samp[j], exp[(j % 44) / CPB]);
            end
        end
        @(negedge clk);
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy_v[0]); end
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (txd_v[0] !== 1'b1) low_seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL no_sixth_frame: line low %b want 0", low_seen); end
    endtask

    task automatic test_mid_reset();
        logic low_seen;
        logic busy_seen;
        send_v[0] = 1'b1;
        data_v[0] = 8'h00;
        repeat (3) @(negedge clk);
        send_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (txd_v[0] !== 1'b0) begin errors++; $display("FAIL rst_pre_data_bit: got %b want 0", txd_v[0]); end
        #2 reset = 1'b1;
        #1;
        checks++; if (txd_v[0] !== 1'b1) begin errors++; $display("FAIL rst_async_txd: got %b want 1", txd_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy_v[0]); end
        checks++; if (full_v[0] !== 1'b0) begin errors++; $display("FAIL rst_async_full: got %b want 0", full_v[0]); end
        @(negedge clk);
        reset = 1'b0;
        low_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd_v[0] !== 1'b1) low_seen = 1'b1;
            if (busy_v[0] !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (low_seen !== 1'b0) begin errors++; $display("FAIL rst_no_resume_txd: line low %b want 0", low_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL rst_no_resume_busy: busy seen %b want 0", busy_seen); end
    endtask

    task automatic test_data_change();
        logic [10:0] exp;
        exp = frame8e(8'h3C);
        push(0, 8'h3C);
        checks++; if (txd_v[0] !== 1'b1) begin errors++; $display("FAIL hold_latency_txd: got %b want 1", txd_v[0]); end
        @(negedge clk);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                data_v[0] = 8'($urandom);
                checks++;
                if (txd_v[0] !== exp[b]) begin
                    errors++; $display("FAIL hold_frame bit %0d cyc %0d: got %b want %b", b, c, txd_v[0], exp[b]);
                end
                @(negedge clk);
            end
        end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL hold_idle_busy: got %b want 0", busy_v[0]); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_odd_parity();
        test_msb_first();
        test_two_stop();
        test_overflow_back_to_back();
        test_mid_reset();
        test_data_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
